mod_counter: RTL and testbench
==============================

# mod_counter

Programmable modulo up/down counter with a bus-mapped count register and limit register, sharing the tri-state `data` bus used by the CPU's other register blocks. It generalises the basic bus counter: parametrised width, programmable wrap limit, direction control, terminal-count and wrap outputs, and optional saturation. It serves as the program/loop counter and as a general-purpose event counter in the datapath.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8 in current builds): width of the count register, limit register and data bus.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `CS`  input  1  chip select; gates all bus reads and writes.
- `WE`  input  1  bus write enable.
- `OE`  input  1  bus output enable.
- `ADDR`  input  1  register select: 0 = COUNT, 1 = LIMIT.
- `CNT_EN`  input  1  count enable; independent of `CS`.
- `UP_DN`  input  1  direction: 1 = up, 0 = down.
- `SYNC_CLR`  input  1  synchronous clear of COUNT.
- `data`  inout  DATA_WIDTH  shared bus.
- `TC`  output  1  terminal count, combinational.
- `WRAP`  output  1  one-cycle registered pulse on wrap-around.

## Operation
- Reset (`reset`=0, asynchronous): COUNT=0, LIMIT=all ones, WRAP=0. `TC` then follows its equation: 1 if `UP_DN`=0, else 0. `data` is released.
- Read: when `CS`&`OE`&!`WE`, `data` is driven combinationally with the register selected by `ADDR`. Otherwise `data`=Z.
- Write: `CS`&`WE`&!`OE` at a rising edge loads `data` into the register selected by `ADDR`.
- `WE`&`OE` both set with `CS`: invalid. No write, no drive, simulation `$display` error.
- Per-edge priority for COUNT: `SYNC_CLR` > bus write to COUNT > count step.
  - A COUNT write in the same cycle as `CNT_EN` loads the written value with no step.
  - A LIMIT write in the same cycle as `CNT_EN` lets the step use the old LIMIT.
- Up step (`CNT_EN`=1, `UP_DN`=1):
  - If COUNT >= LIMIT (unsigned), COUNT wraps to 0 and WRAP=1 on the next cycle.
  - Otherwise COUNT+1.
- Down step (`UP_DN`=0):
  - If COUNT==0, COUNT wraps to LIMIT and WRAP=1.
  - Otherwise COUNT-1.
- A COUNT above LIMIT (after LIMIT is lowered) wraps to 0 on the next up step.
- `TC` = (`UP_DN` & COUNT>=LIMIT) | (!`UP_DN` & COUNT==0).
- Arithmetic is DATA_WIDTH-bit unsigned. No carry out.
- LIMIT=0: in up mode, every enabled step gives COUNT=0 with WRAP=1.

## Timing
- COUNT and LIMIT update 1 cycle after the qualifying edge. Read data is valid in the same cycle as `OE`.
- WRAP is high for exactly the one cycle after the wrapping edge. Back-to-back wraps (LIMIT=0) hold WRAP high continuously.
- `SYNC_CLR` does not assert WRAP.
- Reset asserted mid-count clears immediately without waiting for a clock edge. The first step happens on the first edge after `reset` deasserts.

## Configuration
- `MOD_COUNTER_SAT_EN` defined:
  - The counter saturates instead of wrapping. Up mode holds at LIMIT (or holds any value above LIMIT); down mode holds at 0.
  - WRAP is tied to 0. `TC` is unchanged.
- `MOD_COUNTER_SAT_EN` undefined: wrap behaviour as above.

## Structure
- `ADDR` encodings (`MC_ADDR_COUNT`=0, `MC_ADDR_LIMIT`=1) live in the shared defines header alongside `` `DATA_WIDTH ``.
- The next-count logic (step/wrap/saturate) is a natural combinational sub-module, `mod_counter_next`, with inputs COUNT, LIMIT and `UP_DN` and outputs next value and wrap flag.
- Registers and bus logic stay in `mod_counter`.

## Test plan
- Reset: `reset`=0 mid-count, LIMIT=5 → COUNT reads 0 and LIMIT reads 0xFF immediately, WRAP=0.
- Up wrap: LIMIT=3, `CNT_EN`=1, `UP_DN`=1 for 5 cycles → COUNT 1,2,3,0,1. WRAP high only in the cycle after 3→0. `TC`=1 while COUNT=3.
- Down wrap: LIMIT=3, COUNT=1, down for 3 cycles → 0,3,2. `TC`=1 at 0. WRAP pulses after 0→3.
- Priority: `SYNC_CLR`, COUNT write of 0x20 and `CNT_EN` all set on one edge → COUNT=0. Next edge, write 0x20 with `CNT_EN` → COUNT=0x20, not 0x21.
- Bus: `WE`=`OE`=1 with `CS` → register unchanged, `data`=Z. `CS`=0 with `OE`=1 → `data`=Z.
- Saturate build (`MOD_COUNTER_SAT_EN`): LIMIT=2, up for 4 cycles → COUNT 1,2,2,2, WRAP never asserted.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo up/down bus counter: default width and register select codes.
// Imported by the counter top, its next-count logic and the bus interface users.
package mod_counter_pkg;

   localparam int MC_DATA_WIDTH = 8;

   typedef enum logic {
      MC_ADDR_COUNT = 1'b0,
      MC_ADDR_LIMIT = 1'b1
   } mc_addr_e;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of the modulo counter; the shared tri-state data bus stays a plain port.
// master = CPU/bus side, slave = counter block.
interface mod_counter_if;

   logic CS;
   logic WE;
   logic OE;
   logic ADDR;
   logic CNT_EN;
   logic UP_DN;
   logic SYNC_CLR;
   logic TC;
   logic WRAP;

   modport master (
      output CS, WE, OE, ADDR, CNT_EN, UP_DN, SYNC_CLR,
      input  TC, WRAP
   );

   modport slave (
      input  CS, WE, OE, ADDR, CNT_EN, UP_DN, SYNC_CLR,
      output TC, WRAP
   );

endinterface

// File: rtl/mod_counter_next.sv
// Next-count logic: one up/down step against LIMIT, purely combinational, no flow control.
// MOD_COUNTER_SAT_EN selects saturation instead of wrap-around (wrap flag then stays 0).
module mod_counter_next
   import mod_counter_pkg::*;
#(
   parameter int DATA_WIDTH = MC_DATA_WIDTH
)
(
   input  logic [DATA_WIDTH-1:0] i_count,
   input  logic [DATA_WIDTH-1:0] i_limit,
   input  logic                  i_up_dn,
   output logic [DATA_WIDTH-1:0] o_next,
   output logic                  o_wrap
);

   always_comb begin
      o_next = i_count;
      o_wrap = 1'b0;
      if (i_up_dn) begin
         // >= rather than == so a COUNT left above a lowered LIMIT still terminates
         if (i_count >= i_limit) begin
`ifdef MOD_COUNTER_SAT_EN
            o_next = i_count;
`else
            o_next = '0;
            o_wrap = 1'b1;
`endif
         end else begin
            o_next = i_count + DATA_WIDTH'(1);
         end
      end else begin
         if (i_count == '0) begin
`ifdef MOD_COUNTER_SAT_EN
            o_next = '0;
`else
            o_next = i_limit;
            o_wrap = 1'b1;
`endif
         end else begin
            o_next = i_count - DATA_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Bus-mapped modulo up/down counter (COUNT/LIMIT registers), 1-cycle update, combinational read, no backpressure.
// Build option MOD_COUNTER_SAT_EN: saturate at LIMIT/0 instead of wrapping; WRAP then never asserts.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int DATA_WIDTH = MC_DATA_WIDTH
)
(
   input  logic                  clk,
   input  logic                  reset,
   mod_counter_if.slave          bus,
   inout  wire  [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] r_count;
   logic [DATA_WIDTH-1:0] r_limit;
   logic                  r_wrap;

   logic                  w_rd;
   logic                  w_wr;
   logic                  w_wr_count;
   logic                  w_wr_limit;
   logic [DATA_WIDTH-1:0] w_rd_dat;
   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_step_wrap;

   // WE and OE together is an illegal bus cycle: neither qualifier fires
   assign w_rd       = bus.CS & bus.OE & ~bus.WE;
   assign w_wr       = bus.CS & bus.WE & ~bus.OE;
   assign w_wr_count = w_wr & (bus.ADDR == MC_ADDR_COUNT);
   assign w_wr_limit = w_wr & (bus.ADDR == MC_ADDR_LIMIT);

   assign w_rd_dat = (bus.ADDR == MC_ADDR_LIMIT) ? r_limit : r_count;
   assign data     = w_rd ? w_rd_dat : 'z;

   mod_counter_next #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_next (
      .i_count (r_count),
      .i_limit (r_limit),
      .i_up_dn (bus.UP_DN),
      .o_next  (w_next),
      .o_wrap  (w_step_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_limit <= '1;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (bus.SYNC_CLR) begin
            r_count <= '0;
         end else if (w_wr_count) begin
            r_count <= data;
         end else if (bus.CNT_EN) begin
            r_count <= w_next;
            r_wrap  <= w_step_wrap;
         end
         // step above already used the pre-write LIMIT
         if (w_wr_limit) begin
            r_limit <= data;
         end
      end
   end

   assign bus.TC = bus.UP_DN ? (r_count >= r_limit) : (r_count == '0);

`ifdef MOD_COUNTER_SAT_EN
   assign bus.WRAP = 1'b0;
`else
   assign bus.WRAP = r_wrap;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: vector table through a scoreboard queue plus hand-written corner sequences.
// Expectations follow the MOD_COUNTER_SAT_EN build setting.
module tb_mod_counter;
   import mod_counter_pkg::*;

   localparam int W = MC_DATA_WIDTH;

   logic         clk = 1'b0;
   logic         reset;
   wire  [W-1:0] data;
   logic         tb_drv;
   logic [W-1:0] tb_val;
   logic [W-1:0] rd;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign data = tb_drv ? tb_val : 'z;

   mod_counter_if u_if ();

   mod_counter #(.DATA_WIDTH(W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave),
      .data  (data)
   );

   typedef struct {
      logic         en;
      logic         up;
      logic         clr;
      logic [W-1:0] e_count;
      logic         e_tc;
      logic         e_wrap;
   } vec_t;

   typedef struct {
      logic [W-1:0] count;
      logic         tc;
      logic         wrap;
   } exp_t;

   vec_t vecs[12];
   int   n_vec;
   exp_t sb_q[$];

`ifdef MOD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      u_if.CS       = 1'b0;
      u_if.WE       = 1'b0;
      u_if.OE       = 1'b0;
      u_if.ADDR     = MC_ADDR_COUNT;
      u_if.CNT_EN   = 1'b0;
      u_if.SYNC_CLR = 1'b0;
      tb_drv        = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic addr, input logic [W-1:0] val);
      u_if.CS   = 1'b1;
      u_if.WE   = 1'b1;
      u_if.OE   = 1'b0;
      u_if.ADDR = addr;
      tb_drv    = 1'b1;
      tb_val    = val;
      tick();
      u_if.CS   = 1'b0;
      u_if.WE   = 1'b0;
      tb_drv    = 1'b0;
   endtask

   task automatic bus_read(input logic addr, output logic [W-1:0] val);
      u_if.CS   = 1'b1;
      u_if.OE   = 1'b1;
      u_if.WE   = 1'b0;
      u_if.ADDR = addr;
      #1;
      val       = data;
      u_if.CS   = 1'b0;
      u_if.OE   = 1'b0;
   endtask

   initial begin
      exp_t e;

      idle();
      u_if.UP_DN = 1'b0;
      tb_val     = '0;
      reset      = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;

      // reset state
      bus_read(MC_ADDR_COUNT, rd);
      check("reset count", rd, 0);
      bus_read(MC_ADDR_LIMIT, rd);
      check("reset limit", rd, 8'hFF);
      check("reset wrap", u_if.WRAP, 0);
      check("reset tc down", u_if.TC, 1);
      u_if.UP_DN = 1'b1;
      #1;
      check("reset tc up", u_if.TC, 0);

      // vector table
      n_vec = 0;
      if (!SAT) begin
         vecs[n_vec++] = '{1, 1, 0, 8'd1, 0, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd2, 0, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd3, 1, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd0, 0, 1};
         vecs[n_vec++] = '{1, 1, 0, 8'd1, 0, 0};
         vecs[n_vec++] = '{0, 1, 0, 8'd1, 0, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd0, 1, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd3, 0, 1};
         vecs[n_vec++] = '{1, 0, 0, 8'd2, 0, 0};
         vecs[n_vec++] = '{1, 1, 1, 8'd0, 0, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd3, 0, 1};
         vecs[n_vec++] = '{1, 0, 1, 8'd0, 1, 0};
         bus_write(MC_ADDR_LIMIT, 8'd3);
      end else begin
         vecs[n_vec++] = '{1, 1, 0, 8'd1, 0, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd2, 1, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd2, 1, 0};
         vecs[n_vec++] = '{1, 1, 0, 8'd2, 1, 0};
         vecs[n_vec++] = '{0, 1, 0, 8'd2, 1, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd1, 0, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd0, 1, 0};
         vecs[n_vec++] = '{1, 0, 0, 8'd0, 1, 0};
         vecs[n_vec++] = '{1, 1, 1, 8'd0, 0, 0};
         bus_write(MC_ADDR_LIMIT, 8'd2);
      end

      u_if.CS   = 1'b1;
      u_if.OE   = 1'b1;
      u_if.WE   = 1'b0;
      u_if.ADDR = MC_ADDR_COUNT;
      for (int i = 0; i < n_vec; i++) begin
         u_if.CNT_EN   = vecs[i].en;
         u_if.UP_DN    = vecs[i].up;
         u_if.SYNC_CLR = vecs[i].clr;
         sb_q.push_back('{vecs[i].e_count, vecs[i].e_tc, vecs[i].e_wrap});
         tick();
         e = sb_q.pop_front();
         check($sformatf("vec%0d count", i), data, e.count);
         check($sformatf("vec%0d tc", i), u_if.TC, e.tc);
         check($sformatf("vec%0d wrap", i), u_if.WRAP, e.wrap);
      end
      idle();

      // LIMIT=0: every up step wraps, WRAP held high
      bus_write(MC_ADDR_LIMIT, 8'd0);
      bus_write(MC_ADDR_COUNT, 8'd2);
      u_if.UP_DN  = 1'b1;
      u_if.CNT_EN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus_read(MC_ADDR_COUNT, rd);
         check($sformatf("lim0 count%0d", i), rd, SAT ? 8'd2 : 8'd0);
         check($sformatf("lim0 wrap%0d", i), u_if.WRAP, SAT ? 0 : 1);
      end
      idle();

      // priority: clear beats write beats step
      bus_write(MC_ADDR_LIMIT, 8'hFF);
      bus_write(MC_ADDR_COUNT, 8'h10);
      u_if.SYNC_CLR = 1'b1;
      u_if.CNT_EN   = 1'b1;
      u_if.UP_DN    = 1'b1;
      bus_write(MC_ADDR_COUNT, 8'h20);
      idle();
      check("prio clr wrap", u_if.WRAP, 0);
      bus_read(MC_ADDR_COUNT, rd);
      check("prio clr count", rd, 0);
      u_if.CNT_EN = 1'b1;
      bus_write(MC_ADDR_COUNT, 8'h20);
      idle();
      bus_read(MC_ADDR_COUNT, rd);
      check("prio write count", rd, 8'h20);

      // LIMIT write alongside a step: step sees the old LIMIT
      bus_write(MC_ADDR_LIMIT, 8'd3);
      bus_write(MC_ADDR_COUNT, 8'd3);
      u_if.CNT_EN = 1'b1;
      u_if.UP_DN  = 1'b1;
      bus_write(MC_ADDR_LIMIT, 8'h10);
      idle();
      check("oldlim wrap", u_if.WRAP, SAT ? 0 : 1);
      bus_read(MC_ADDR_COUNT, rd);
      check("oldlim count", rd, SAT ? 8'd3 : 8'd0);
      bus_read(MC_ADDR_LIMIT, rd);
      check("oldlim limit", rd, 8'h10);

      // illegal WE+OE and deselected OE: no write, bus released
      bus_write(MC_ADDR_COUNT, 8'h21);
      u_if.CS   = 1'b1;
      u_if.WE   = 1'b1;
      u_if.OE   = 1'b1;
      u_if.ADDR = MC_ADDR_COUNT;
      tb_drv    = 1'b1;
      tb_val    = 8'h5A;
      #1;
      check("weoe release", data, 8'h5A);
      tick();
      idle();
      bus_read(MC_ADDR_COUNT, rd);
      check("weoe count", rd, 8'h21);
      u_if.CS = 1'b0;
      u_if.OE = 1'b1;
      tb_drv  = 1'b1;
      tb_val  = 8'h5A;
      #1;
      check("cs0 release", data, 8'h5A);
      idle();

      // asynchronous reset right after a wrap
      bus_write(MC_ADDR_LIMIT, 8'd5);
      bus_write(MC_ADDR_COUNT, 8'd0);
      u_if.CNT_EN = 1'b1;
      u_if.UP_DN  = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("pre-rst wrap", u_if.WRAP, SAT ? 0 : 1);
      bus_read(MC_ADDR_COUNT, rd);
      check("pre-rst count", rd, SAT ? 8'd5 : 8'd0);
      #1;
      reset = 1'b0;
      #1;
      check("async rst wrap", u_if.WRAP, 0);
      bus_read(MC_ADDR_COUNT, rd);
      check("async rst count", rd, 0);
      bus_read(MC_ADDR_LIMIT, rd);
      check("async rst limit", rd, 8'hFF);
      #1;
      reset = 1'b1;
      tick();
      bus_read(MC_ADDR_COUNT, rd);
      check("first step count", rd, 8'd1);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
